// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard unit bundle: ID-stage instruction fields and memory freeze in,
// stage enables, bubble inserts and bypass selects out.
//   master : pipeline side (drives ID fields, receives controls)
//   slave  : hazard unit side
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_W = 5
);
  logic             mem_stall;
  logic             Branch_ID;
  logic             rs1use_ID;
  logic             rs2use_ID;
  logic [2:0]       hazard_optype_ID;
  logic [REG_W-1:0] rd_ID;
  logic [REG_W-1:0] rs1_ID;
  logic [REG_W-1:0] rs2_ID;

  logic             PC_EN_IF;
  logic             reg_FD_EN;
  logic             reg_DE_EN;
  logic             reg_EM_EN;
  logic             reg_MW_EN;
  logic             reg_FD_flush;
  logic             reg_DE_flush;
  logic             reg_EM_flush;
  logic [1:0]       forward_ctrl_A;
  logic [1:0]       forward_ctrl_B;
  logic             forward_ctrl_ls;
  logic             mul_busy;

  modport master (
    output mem_stall, Branch_ID, rs1use_ID, rs2use_ID, hazard_optype_ID,
           rd_ID, rs1_ID, rs2_ID,
    input  PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
           reg_FD_flush, reg_DE_flush, reg_EM_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy
  );

  modport slave (
    input  mem_stall, Branch_ID, rs1use_ID, rs2use_ID, hazard_optype_ID,
           rd_ID, rs1_ID, rs2_ID,
    output PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN,
           reg_FD_flush, reg_DE_flush, reg_EM_flush,
           forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, mul_busy
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard scoreboard for the 5-stage core. Tracks the EXE and MEM
// instructions (optype, rd, EXE rs2) and a MUL occupancy counter, and from
// them plus the ID fields produces stage enables, bubble inserts and the
// operand / store-data bypass selects combinationally.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   hz   hazard bundle (slave): ID fields + mem_stall in, controls out
module hazard_scoreboard_unit #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned CNT_W      = 4,
  parameter bit          FORWARD_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_ALU   = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXE  = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MLD  = 2'b11;

  logic [2:0]       opt_exe, opt_mem;
  logic [REG_W-1:0] rd_exe, rs2_exe, rd_mem;
  logic [CNT_W-1:0] cnt;

  logic exe_wr, mem_wr, busy, lu, raw;
  logic exe_fwd_ok, mem_alu_ok, mem_ld_ok;

  // Bypass source for one operand; the EXE match shadows the MEM match.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             e_ok,
    input logic [REG_W-1:0] e_rd,
    input logic             m_alu,
    input logic             m_ld,
    input logic [REG_W-1:0] m_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (e_ok && (rs == e_rd))        sel = FWD_EXE;
    else if (m_alu && (rs == m_rd))  sel = FWD_MALU;
    else if (m_ld && (rs == m_rd))   sel = FWD_MLD;
    return sel;
  endfunction

  // Hazard detection; a zero rd never counts as a producer.
  always_comb begin
    exe_wr = ((opt_exe == OP_ALU) || (opt_exe == OP_LOAD) || (opt_exe == OP_MUL))
             && (rd_exe != '0);
    mem_wr = ((opt_mem == OP_ALU) || (opt_mem == OP_LOAD) || (opt_mem == OP_MUL))
             && (rd_mem != '0);
    busy   = (cnt != '0);

    // Store data arrives late via forward_ctrl_ls, so a store's rs2 is exempt.
    lu = (opt_exe == OP_LOAD) && (rd_exe != '0) &&
         ((hz.rs1use_ID && (hz.rs1_ID == rd_exe)) ||
          (hz.rs2use_ID && (hz.rs2_ID == rd_exe) && (hz.hazard_optype_ID != OP_STORE)));

    raw = 1'b0;
    if (!FORWARD_EN) begin
      raw = (hz.rs1use_ID && ((exe_wr && (hz.rs1_ID == rd_exe)) ||
                              (mem_wr && (hz.rs1_ID == rd_mem)))) ||
            (hz.rs2use_ID && ((exe_wr && (hz.rs2_ID == rd_exe)) ||
                              (mem_wr && (hz.rs2_ID == rd_mem))));
    end

    // A MUL result is only valid in its final EXE cycle.
    exe_fwd_ok = (rd_exe != '0) && (cnt == '0) &&
                 ((opt_exe == OP_ALU) || (opt_exe == OP_MUL));
    mem_alu_ok = (rd_mem != '0) && ((opt_mem == OP_ALU) || (opt_mem == OP_MUL));
    mem_ld_ok  = (rd_mem != '0) && (opt_mem == OP_LOAD);
  end

  // Stage enables, bubbles and bypass selects.
  always_comb begin
    hz.PC_EN_IF        = 1'b1;
    hz.reg_FD_EN       = 1'b1;
    hz.reg_DE_EN       = 1'b1;
    hz.reg_EM_EN       = 1'b1;
    hz.reg_MW_EN       = 1'b1;
    hz.reg_FD_flush    = 1'b0;
    hz.reg_DE_flush    = 1'b0;
    hz.reg_EM_flush    = 1'b0;
    hz.forward_ctrl_A  = FWD_RF;
    hz.forward_ctrl_B  = FWD_RF;
    hz.forward_ctrl_ls = 1'b0;

    if (hz.mem_stall) begin
      hz.PC_EN_IF  = 1'b0;
      hz.reg_FD_EN = 1'b0;
      hz.reg_DE_EN = 1'b0;
      hz.reg_EM_EN = 1'b0;
      hz.reg_MW_EN = 1'b0;
    end else if (busy) begin
      hz.PC_EN_IF     = 1'b0;
      hz.reg_FD_EN    = 1'b0;
      hz.reg_DE_EN    = 1'b0;
      hz.reg_EM_flush = 1'b1;
    end else if (lu || raw) begin
      hz.PC_EN_IF     = 1'b0;
      hz.reg_FD_EN    = 1'b0;
      hz.reg_DE_flush = 1'b1;
    end else begin
      // Under any stall the branch is simply re-evaluated next cycle.
      hz.reg_FD_flush = hz.Branch_ID;
    end

    if (FORWARD_EN) begin
      hz.forward_ctrl_A  = fwd_sel(hz.rs1_ID, exe_fwd_ok, rd_exe, mem_alu_ok, mem_ld_ok, rd_mem);
      hz.forward_ctrl_B  = fwd_sel(hz.rs2_ID, exe_fwd_ok, rd_exe, mem_alu_ok, mem_ld_ok, rd_mem);
      hz.forward_ctrl_ls = (opt_exe == OP_STORE) && mem_ld_ok && (rs2_exe == rd_mem);
    end
  end

  assign hz.mul_busy = busy;

  // EXE/MEM tracking and MUL occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opt_exe <= OP_NONE;
      rd_exe  <= '0;
      rs2_exe <= '0;
      opt_mem <= OP_NONE;
      rd_mem  <= '0;
      cnt     <= '0;
    end else if (!hz.mem_stall) begin
      if (busy) begin
        opt_mem <= OP_NONE;
        rd_mem  <= '0;
        cnt     <= cnt - CNT_W'(1);
      end else if (lu || raw) begin
        opt_mem <= opt_exe;
        rd_mem  <= rd_exe;
        opt_exe <= OP_NONE;
        rd_exe  <= '0;
        rs2_exe <= '0;
      end else begin
        opt_mem <= opt_exe;
        rd_mem  <= rd_exe;
        opt_exe <= hz.hazard_optype_ID;
        rd_exe  <= hz.rd_ID;
        rs2_exe <= hz.rs2_ID;
        cnt     <= (hz.hazard_optype_ID == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: two units (bypass on / bypass off) share one stimulus
// stream and are compared against an instruction-level pipeline model.
module tb_hazard_scoreboard_unit;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] ALU   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] MUL   = 3'd4;

  // {PC,FD,DE,EM,MW, FDf,DEf,EMf, fwdA[1:0], fwdB[1:0], ls, busy}
  localparam logic [13:0] IDLE = 14'b11111_000_00_00_0_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             ms, br, u1, u2;
  logic [2:0]       op;
  logic [REG_W-1:0] rd, rs1, rs2;

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_scoreboard_unit_if #(.REG_W(REG_W)) if0 ();
  hazard_scoreboard_unit_if #(.REG_W(REG_W)) if1 ();

  assign if0.mem_stall = ms;  assign if1.mem_stall = ms;
  assign if0.Branch_ID = br;  assign if1.Branch_ID = br;
  assign if0.rs1use_ID = u1;  assign if1.rs1use_ID = u1;
  assign if0.rs2use_ID = u2;  assign if1.rs2use_ID = u2;
  assign if0.hazard_optype_ID = op;  assign if1.hazard_optype_ID = op;
  assign if0.rd_ID  = rd;   assign if1.rd_ID  = rd;
  assign if0.rs1_ID = rs1;  assign if1.rs1_ID = rs1;
  assign if0.rs2_ID = rs2;  assign if1.rs2_ID = rs2;

  hazard_scoreboard_unit #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .FORWARD_EN(1'b1))
    dut0 (.clk(clk), .rst(rst), .hz(if0));
  hazard_scoreboard_unit #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .FORWARD_EN(1'b0))
    dut1 (.clk(clk), .rst(rst), .hz(if1));

  logic [13:0] o0, o1;
  assign o0 = {if0.PC_EN_IF, if0.reg_FD_EN, if0.reg_DE_EN, if0.reg_EM_EN, if0.reg_MW_EN,
               if0.reg_FD_flush, if0.reg_DE_flush, if0.reg_EM_flush,
               if0.forward_ctrl_A, if0.forward_ctrl_B, if0.forward_ctrl_ls, if0.mul_busy};
  assign o1 = {if1.PC_EN_IF, if1.reg_FD_EN, if1.reg_DE_EN, if1.reg_EM_EN, if1.reg_MW_EN,
               if1.reg_FD_flush, if1.reg_DE_flush, if1.reg_EM_flush,
               if1.forward_ctrl_A, if1.forward_ctrl_B, if1.forward_ctrl_ls, if1.mul_busy};

  // Model: the instruction in EXE and MEM, and how many EXE cycles the
  // current MUL still occupies (counting the present one). Index 0 = bypass on.
  logic [2:0]       m_eop [2];
  logic [2:0]       m_mop [2];
  logic [REG_W-1:0] m_erd [2];
  logic [REG_W-1:0] m_ers2[2];
  logic [REG_W-1:0] m_mrd [2];
  int               m_left[2];

  function automatic logic writes(input logic [2:0] o);
    return (o == ALU) || (o == LOAD) || (o == MUL);
  endfunction

  function automatic logic m_busy(input int v);
    return m_left[v] > 1;
  endfunction

  // Register r is being produced by an in-flight instruction.
  function automatic logic m_pending(input int v, input logic [REG_W-1:0] r);
    if (r == 0) return 1'b0;
    return (writes(m_eop[v]) && r == m_erd[v]) || (writes(m_mop[v]) && r == m_mrd[v]);
  endfunction

  function automatic logic m_hazard(input int v);
    logic lu, raw;
    lu  = (m_eop[v] == LOAD) && (m_erd[v] != 0) &&
          ((u1 && rs1 == m_erd[v]) || (u2 && rs2 == m_erd[v] && op != STORE));
    raw = (v == 1) && ((u1 && m_pending(v, rs1)) || (u2 && m_pending(v, rs2)));
    return lu || raw;
  endfunction

  function automatic logic [1:0] m_src(input int v, input logic [REG_W-1:0] r);
    if (v == 1 || r == 0) return 2'b00;
    if (r == m_erd[v] && (m_eop[v] == ALU || (m_eop[v] == MUL && m_left[v] <= 1))) return 2'b01;
    if (r == m_mrd[v] && (m_mop[v] == ALU || m_mop[v] == MUL)) return 2'b10;
    if (r == m_mrd[v] && m_mop[v] == LOAD) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [13:0] exp_out(input int v);
    logic [4:0] en;
    logic [2:0] fl;
    logic       ls;
    if (ms)                 begin en = 5'b00000; fl = 3'b000; end
    else if (m_busy(v))     begin en = 5'b00011; fl = 3'b001; end
    else if (m_hazard(v))   begin en = 5'b00111; fl = 3'b010; end
    else                    begin en = 5'b11111; fl = {br, 2'b00}; end
    ls = (v == 0) && m_eop[v] == STORE && m_mop[v] == LOAD && m_mrd[v] != 0 &&
         m_ers2[v] == m_mrd[v];
    return {en, fl, m_src(v, rs1), m_src(v, rs2), ls, m_busy(v)};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_eop[v] = NONE; m_mop[v] = NONE; m_erd[v] = 0; m_ers2[v] = 0; m_mrd[v] = 0;
      m_left[v] = 0;
    end
  endtask

  task automatic model_advance();
    for (int v = 0; v < 2; v++) begin
      if (rst) begin
        m_eop[v] = NONE; m_mop[v] = NONE; m_erd[v] = 0; m_ers2[v] = 0; m_mrd[v] = 0;
        m_left[v] = 0;
      end else if (!ms) begin
        if (m_busy(v)) begin
          m_mop[v] = NONE; m_mrd[v] = 0; m_left[v]--;
        end else if (m_hazard(v)) begin
          m_mop[v] = m_eop[v]; m_mrd[v] = m_erd[v];
          m_eop[v] = NONE; m_erd[v] = 0; m_ers2[v] = 0; m_left[v] = 0;
        end else begin
          m_mop[v] = m_eop[v]; m_mrd[v] = m_erd[v];
          m_eop[v] = op; m_erd[v] = rd; m_ers2[v] = rs2;
          m_left[v] = (op == MUL) ? int'(MUL_LAT) : 0;
        end
      end
    end
  endtask

  task automatic set_in(input logic s, input logic b, input logic [2:0] o,
                        input logic [REG_W-1:0] d, input logic [REG_W-1:0] a,
                        input logic [REG_W-1:0] c, input logic ua, input logic uc);
    ms = s; br = b; op = o; rd = d; rs1 = a; rs2 = c; u1 = ua; u2 = uc;
  endtask

  // One clock: model follows the edge, inputs change after the falling edge.
  task automatic step();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic drain();
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (o0 !== IDLE) begin tests_failed++; $display("FAIL reset_dut0 got %b exp %b", o0, IDLE); end
    tests_run++;
    if (o1 !== IDLE) begin tests_failed++; $display("FAIL reset_dut1 got %b exp %b", o1, IDLE); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (o0 !== IDLE) begin tests_failed++; $display("FAIL post_reset got %b exp %b", o0, IDLE); end
    step();
  endtask

  task automatic test_mul_forward();
    set_in(0, 0, MUL, 5, 1, 2, 1, 1);
    step();
    set_in(0, 0, ALU, 6, 5, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({o0[13], o0[6], o0[0]} !== 3'b011) begin
        tests_failed++;
        $display("FAIL mul_busy_cycle%0d got pc/emf/busy=%b exp 011", i, {o0[13], o0[6], o0[0]});
      end
      step();
    end
    #1;
    tests_run++;
    if ({o0[13], o0[5:4], o0[0]} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL mul_fwd got pc/fwdA/busy=%b exp 1010", {o0[13], o0[5:4], o0[0]});
    end
    step();
    drain();
  endtask

  task automatic test_load_use();
    set_in(0, 0, LOAD, 3, 2, 0, 1, 0);
    step();
    set_in(0, 0, ALU, 4, 3, 3, 1, 1);
    #1;
    tests_run++;
    if ({o0[13], o0[7]} !== 2'b01) begin
      tests_failed++; $display("FAIL lu_stall got pc/def=%b exp 01", {o0[13], o0[7]});
    end
    step();
    #1;
    tests_run++;
    if ({o0[13], o0[7], o0[5:2]} !== 6'b10_1111) begin
      tests_failed++; $display("FAIL lu_fwd got pc/def/fA/fB=%b exp 101111", {o0[13], o0[7], o0[5:2]});
    end
    step();
    drain();
  endtask

  task automatic test_store_fwd();
    set_in(0, 0, LOAD, 3, 2, 0, 1, 0);
    step();
    set_in(0, 0, STORE, 0, 2, 3, 1, 1);
    #1;
    tests_run++;
    if ({o0[13], o0[7]} !== 2'b10) begin
      tests_failed++; $display("FAIL store_nostall got pc/def=%b exp 10", {o0[13], o0[7]});
    end
    step();
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (o0[1] !== 1'b1) begin tests_failed++; $display("FAIL store_ls got %b exp 1", o0[1]); end
    step();
    drain();
    set_in(0, 0, LOAD, 0, 2, 0, 1, 0);
    step();
    set_in(0, 0, ALU, 4, 0, 0, 1, 1);
    #1;
    tests_run++;
    if ({o0[13], o0[7], o0[5:2]} !== 6'b10_0000) begin
      tests_failed++; $display("FAIL x0_load got pc/def/fA/fB=%b exp 100000", {o0[13], o0[7], o0[5:2]});
    end
    step();
    drain();
  endtask

  task automatic test_exe_priority();
    set_in(0, 0, LOAD, 7, 1, 0, 1, 0);
    step();
    set_in(0, 0, ALU, 7, 1, 1, 1, 1);
    step();
    set_in(0, 0, ALU, 8, 7, 0, 1, 1);
    #1;
    tests_run++;
    if (o0[5:2] !== 4'b0100) begin
      tests_failed++; $display("FAIL exe_priority got fA/fB=%b exp 0100", o0[5:2]);
    end
    step();
    drain();
    set_in(0, 0, LOAD, 3, 2, 0, 1, 0);
    step();
    set_in(0, 1, NONE, 0, 3, 0, 1, 0);
    #1;
    tests_run++;
    if ({o0[13], o0[8], o0[7]} !== 3'b001) begin
      tests_failed++; $display("FAIL branch_in_lu got pc/fdf/def=%b exp 001", {o0[13], o0[8], o0[7]});
    end
    step();
    #1;
    tests_run++;
    if ({o0[13], o0[8]} !== 2'b11) begin
      tests_failed++; $display("FAIL branch_after_lu got pc/fdf=%b exp 11", {o0[13], o0[8]});
    end
    step();
    drain();
  endtask

  task automatic test_mem_stall();
    int n;
    set_in(0, 0, MUL, 5, 0, 0, 0, 0);
    step();
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    step();
    set_in(1, 0, NONE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if ({o0[13:6], o0[0]} !== 9'b00000000_1) begin
        tests_failed++; $display("FAIL mem_stall%0d got en/fl/busy=%b exp 000000001", i, {o0[13:6], o0[0]});
      end
      step();
    end
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!o0[0]) break;
      n++;
      step();
    end
    tests_run++;
    if (n != 2) begin tests_failed++; $display("FAIL mul_resume got %0d busy cycles exp 2", n); end
    step();
    drain();
  endtask

  task automatic test_no_forward();
    int n;
    set_in(0, 0, ALU, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, ALU, 2, 1, 1, 1, 1);
    #1;
    tests_run++;
    if ({o0[13], o0[5:2]} !== 5'b1_0101) begin
      tests_failed++; $display("FAIL fwd_on_ref got pc/fA/fB=%b exp 10101", {o0[13], o0[5:2]});
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (o1[5:1] !== 5'b00000) begin
        tests_failed++; $display("FAIL nofwd_zero got fA/fB/ls=%b exp 00000", o1[5:1]);
      end
      if (o1[13]) break;
      n++;
      step();
      #1;
    end
    tests_run++;
    if (n != 2) begin tests_failed++; $display("FAIL nofwd_stalls got %0d exp 2", n); end
    step();
    drain();
  endtask

  task automatic test_async_reset();
    set_in(0, 0, MUL, 5, 0, 0, 0, 0);
    step();
    set_in(0, 0, NONE, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (o0[0] !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_busy got %b exp 1", o0[0]); end
    #1 rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (o0 !== IDLE) begin tests_failed++; $display("FAIL async_rst_dut0 got %b exp %b", o0, IDLE); end
    tests_run++;
    if (o1 !== IDLE) begin tests_failed++; $display("FAIL async_rst_dut1 got %b exp %b", o1, IDLE); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] e0, e1;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
             REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
             REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      e0 = exp_out(0);
      e1 = exp_out(1);
      tests_run++;
      if (o0 !== e0) begin tests_failed++; $display("FAIL random_fwd cyc%0d got %b exp %b", i, o0, e0); end
      tests_run++;
      if (o1 !== e1) begin tests_failed++; $display("FAIL random_nofwd cyc%0d got %b exp %b", i, o1, e1); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_mul_forward();
    test_load_use();
    test_store_fwd();
    test_exe_priority();
    test_mem_stall();
    test_no_forward();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1);
  end

endmodule
